// File: rtl/serial_adder_seq.sv
// serial_adder_seq
//   Multi-cycle adder/subtractor. WIDTH-bit operands are processed SLICE bits per
//   RUN cycle, with a registered carry chained from one slice to the next.
//   Subtraction is a + ~b + 1.
//   It takes WIDTH/SLICE compute cycles after the accept edge.
// Ports
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-high reset
//   start     request, accepted only in IDLE or DONE
//   a, b      operands, captured on the accept edge
//   cin       carry-in for add, ignored when sub=1
//   sub       0: a+b+cin, 1: a-b; captured on the accept edge
//   busy      high while an operation is in flight
//   done      one-cycle pulse when sum/cout/overflow hold a new result
//   sum       result, held until the next operation completes
//   cout      carry out of the MSB (for sub: 1 = no borrow)
//   overflow  signed overflow (carry into MSB xor carry out of MSB)
module serial_adder_seq #(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = $clog2(N) + 1;
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] op_a_r;
    logic [WIDTH-1:0] op_b_r;
    logic [WIDTH-1:0] acc_r;
    logic             carry_r;
    logic [CW-1:0]    count_r;

    logic             accept_s;
    logic             last_s;
    logic [31:0]      shamt_s;
    logic [SLICE-1:0] slice_a_s;
    logic [SLICE-1:0] slice_b_s;
    logic [SLICE-1:0] slice_sum_s;
    logic             slice_cout_s;
    logic             msb_cin_s;
    logic [WIDTH-1:0] acc_s;

    assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));
    assign last_s   = (count_r == CW'(N - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: RUN lasts N cycles, DONE lasts one.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Status outputs are decoded straight from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_r)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Slice adder. The current slice is selected by shifting rather than by
    // a variable part-select. Sum bit = a ^ b ^ carry-in, so the carry into
    // the top bit of the slice is recovered from the sum bit and the two
    // operand bits.
    always_comb begin
        shamt_s   = 32'(count_r) * 32'(SLICE);
        slice_a_s = SLICE'(op_a_r >> shamt_s);
        slice_b_s = SLICE'(op_b_r >> shamt_s);
        {slice_cout_s, slice_sum_s} = {1'b0, slice_a_s} + {1'b0, slice_b_s}
                                    + {{SLICE{1'b0}}, carry_r};
        msb_cin_s = slice_sum_s[SLICE-1] ^ slice_a_s[SLICE-1] ^ slice_b_s[SLICE-1];
        acc_s     = (acc_r & ~(SLICE_MASK << shamt_s)) | (WIDTH'(slice_sum_s) << shamt_s);
    end

    // Datapath: capture operands on accept, add one slice per RUN cycle,
    // and publish the result on the final slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_r   <= '0;
            op_b_r   <= '0;
            acc_r    <= '0;
            carry_r  <= 1'b0;
            count_r  <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept_s) begin
            op_a_r  <= a;
            op_b_r  <= sub ? ~b : b;
            carry_r <= sub ? 1'b1 : cin;
            count_r <= '0;
        end else if (state_r == RUN) begin
            acc_r   <= acc_s;
            carry_r <= slice_cout_s;
            count_r <= count_r + CW'(1);
            if (last_s) begin
                sum      <= acc_s;
                cout     <= slice_cout_s;
                overflow <= msb_cin_s ^ slice_cout_s;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_seq.sv
module tb_serial_adder_seq;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // Cycle counter used to measure accept-to-done latency.
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- W=8, S=1 ----------------
    logic       rst8, st8, cin8, sub8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;

    serial_adder_seq #(.WIDTH(8), .SLICE(1)) u_dut8 (
        .clk(clk), .rst(rst8), .start(st8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
    );

    // ---------------- W=4, S=1/2/4 ----------------
    logic       rst4, st4, cin4, sub4;
    logic [3:0] a4, b4;
    logic       busy4 [3];
    logic       done4 [3];
    logic       cout4 [3];
    logic       ovf4  [3];
    logic [3:0] sum4  [3];

    for (genvar g = 0; g < 3; g++) begin : g_w4
        serial_adder_seq #(.WIDTH(4), .SLICE(1 << g)) u_dut4 (
            .clk(clk), .rst(rst4), .start(st4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
            .busy(busy4[g]), .done(done4[g]), .sum(sum4[g]), .cout(cout4[g]), .overflow(ovf4[g])
        );
    end

    // ---------------- W=16, S=4 ----------------
    logic        rst16, st16, cin16, sub16, busy16, done16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;

    serial_adder_seq #(.WIDTH(16), .SLICE(4)) u_dut16 (
        .clk(clk), .rst(rst16), .start(st16), .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .overflow(ovf16)
    );

    // Scoreboards: expected {overflow, cout, sum[15:0]} and accept cycle.
    logic [17:0] q8[$], q4[$], q16[$];
    int          t8[$], t4[$], t16[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model using two's-complement sign rules for overflow.
    function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic su);
        logic [15:0] mask, am, bb, s;
        logic [16:0] full;
        logic        co, ov, sa, sb, ss;
        mask = 16'((17'd1 << w) - 17'd1);
        am   = a & mask;
        bb   = su ? (~b & mask) : (b & mask);
        full = {1'b0, am} + {1'b0, bb} + {16'd0, (su ? 1'b1 : ci)};
        s    = full[15:0] & mask;
        co   = |(full & (17'd1 << w));
        sa   = |(am & (16'd1 << (w - 1)));
        sb   = |(bb & (16'd1 << (w - 1)));
        ss   = |(s & (16'd1 << (w - 1)));
        ov   = (sa == sb) && (ss != sa);
        return {ov, co, s};
    endfunction

    // Called at a negedge with the W=8 unit in IDLE or DONE.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic su);
        a8 = a; b8 = b; cin8 = ci; sub8 = su; st8 = 1'b1;
        q8.push_back(model(8, {8'd0, a}, {8'd0, b}, ci, su));
        t8.push_back(cyc + 1);
        @(negedge clk);
        st8 = 1'b0;
    endtask

    task automatic wait8();
        int n = 0;
        while (!done8 && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (!done8) chk("timeout8", 32'd0, 32'd1);
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic su);
        a4 = a; b4 = b; cin4 = ci; sub4 = su; st4 = 1'b1;
        q4.push_back(model(4, {12'd0, a}, {12'd0, b}, ci, su));
        t4.push_back(cyc + 1);
        @(negedge clk);
        st4 = 1'b0;
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic su);
        a16 = a; b16 = b; cin16 = ci; sub16 = su; st16 = 1'b1;
        q16.push_back(model(16, a, b, ci, su));
        t16.push_back(cyc + 1);
        @(negedge clk);
        st16 = 1'b0;
        // Scramble inputs mid-flight; the result must not depend on them.
        a16 = 16'($urandom); b16 = 16'($urandom);
        cin16 = 1'($urandom); sub16 = 1'($urandom);
    endtask

    // W=8 result monitor.
    always @(negedge clk) begin
        logic [17:0] e;
        int          t;
        if (done8) begin
            if (q8.size() == 0) begin
                chk("d8_spurious", 32'd1, 32'd0);
            end else begin
                e = q8.pop_front();
                t = t8.pop_front();
                chk("d8_res", 32'({ovf8, cout8, sum8}), 32'({e[17:16], e[7:0]}));
                chk("d8_lat", 32'(cyc - t), 32'd8);
            end
        end
    end

    // W=4 result monitor; the S=1 instance finishes last and retires the entry.
    always @(negedge clk) begin
        logic [17:0] e;
        for (int g = 0; g < 3; g++) begin
            if (done4[g]) begin
                if (q4.size() == 0) begin
                    chk($sformatf("d4_spurious_s%0d", 1 << g), 32'd1, 32'd0);
                end else begin
                    e = q4[0];
                    chk($sformatf("d4_res_s%0d", 1 << g),
                        32'({ovf4[g], cout4[g], sum4[g]}), 32'({e[17:16], e[3:0]}));
                    chk($sformatf("d4_lat_s%0d", 1 << g), 32'(cyc - t4[0]), 32'(4 >> g));
                end
            end
        end
        if (done4[0] && q4.size() != 0) begin
            void'(q4.pop_front());
            void'(t4.pop_front());
        end
    end

    // W=16 result monitor.
    always @(negedge clk) begin
        logic [17:0] e;
        int          t;
        if (done16) begin
            if (q16.size() == 0) begin
                chk("d16_spurious", 32'd1, 32'd0);
            end else begin
                e = q16.pop_front();
                t = t16.pop_front();
                chk("d16_res", 32'({ovf16, cout16, sum16}), 32'(e));
                chk("d16_lat", 32'(cyc - t), 32'd4);
            end
        end
    end

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int gap;
        rst8 = 1'b1; st8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        rst4 = 1'b1; st4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
        rst16 = 1'b1; st16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst8", 32'({busy8, done8, cout8, ovf8, sum8}), 32'd0);
        chk("rst16", 32'({busy16, done16, cout16, ovf16, sum16}), 32'd0);
        for (int g = 0; g < 3; g++)
            chk("rst4", 32'({busy4[g], done4[g], cout4[g], ovf4[g], sum4[g]}), 32'd0);
        rst8 = 1'b0; rst4 = 1'b0; rst16 = 1'b0;
        @(negedge clk);

        // Case 1: 0xFF + 0x01.
        issue8(8'hFF, 8'h01, 1'b0, 1'b0);
        n = 0;
        while (busy8 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("t1_busy_cycles", 32'(n), 32'd8);
        chk("t1_done", 32'(done8), 32'd1);
        chk("t1_res", 32'({ovf8, cout8, sum8}), 32'h100);
        @(negedge clk);
        chk("t1_done_pulse", 32'(done8), 32'd0);

        // Case 2: signed overflow and subtract.
        issue8(8'h7F, 8'h01, 1'b0, 1'b0);
        wait8();
        chk("t2_ovf", 32'({ovf8, cout8, sum8}), 32'h280);
        @(negedge clk);
        issue8(8'h05, 8'h07, 1'b0, 1'b1);
        wait8();
        chk("t2_sub", 32'({ovf8, cout8, sum8}), 32'h0FE);
        @(negedge clk);

        // Case 4: start during RUN is ignored.
        issue8(8'h11, 8'h22, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        st8 = 1'b1; a8 = 8'h55; b8 = 8'h55; sub8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        wait8();
        chk("t4_ignored", 32'({ovf8, cout8, sum8}), 32'h033);
        // Back-to-back start in the DONE cycle.
        issue8(8'h40, 8'h02, 1'b1, 1'b0);
        chk("b2b_done_low", 32'(done8), 32'd0);
        chk("b2b_busy", 32'(busy8), 32'd1);
        chk("b2b_hold", 32'(sum8), 32'h33);
        wait8();
        chk("b2b_res", 32'({ovf8, cout8, sum8}), 32'h043);
        @(negedge clk);

        // Case 5: reset mid-RUN abandons the operation.
        issue8(8'hFF, 8'h01, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        q8.delete();
        t8.delete();
        chk("t5_rst", 32'({busy8, done8, cout8, ovf8, sum8}), 32'd0);
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) n++;
        end
        chk("t5_no_done", 32'(n), 32'd0);
        issue8(8'hFF, 8'h01, 1'b0, 1'b0);
        wait8();
        chk("t5_rerun", 32'({ovf8, cout8, sum8}), 32'h100);
        @(negedge clk);

        // Case 3: exhaustive W=4 for S=1, 2, 4.
        for (int i = 0; i < 1024; i++) begin
            issue4(4'(i), 4'(i >> 4), 1'(i >> 8), 1'(i >> 9));
            for (int g = 0; g < 3; g++) chk("w4_busy", 32'(busy4[g]), 32'd1);
            n = 0;
            while (!done4[0] && n < 20) begin
                n++;
                @(negedge clk);
            end
            if (!done4[0]) chk("timeout4", 32'd0, 32'd1);
            @(negedge clk);
        end

        // Case 6: random W=16, S=4 with random gaps.
        for (int i = 0; i < 1000; i++) begin
            issue16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            chk("w16_busy", 32'(busy16), 32'd1);
            n = 0;
            while (!done16 && n < 20) begin
                n++;
                @(negedge clk);
            end
            if (!done16) chk("timeout16", 32'd0, 32'd1);
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
        end
        repeat (10) @(negedge clk);

        chk("q8_drained", 32'(q8.size()), 32'd0);
        chk("q4_drained", 32'(q4.size()), 32'd0);
        chk("q16_drained", 32'(q16.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
